calc_job_sequencer: RTL and testbench

- Memory-mapped mailbox controller that sequences one calculator job at a time between the evaluate front end and the ARM CPU.
- On an evaluate pulse it captures operands A and B and the operator code. It publishes them to the CPU through a small register window and asserts GO.
- It then waits for the CPU to post a result and write a DONE word, with a timeout.
- It sits beside dmem on the CPU data bus. The top level muxes mbox_rd into ReadData whenever mbox_hit=1.

---
 rtl/calc_job_sequencer.sv | 151 +++++++++++++++
 tb/tb_calc_job_sequencer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/calc_job_sequencer.sv
// calc_job_sequencer
//   Mailbox controller that hands one calculator job at a time to the CPU.
//   An evaluate pulse latches operands/operator, raises GO and waits for the
//   CPU to post a result (RESULT scratch) and acknowledge it with a DONE word
//   carrying the job sequence number. A cycle counter aborts a job that is
//   never acknowledged.
//
//   Register window (word offsets from MBOX_BASE, cpu_addr[1:0] ignored):
//     0x00 A   0x04 B   0x08 OP   0x0C STATUS   0x10 RESULT (r/w)   0x14 DONE (w)
//   STATUS: [0] GO, [1] result_valid, [2] err_timeout, [3] err_badop, [15:8] seq
//
// Ports
//   clk_50mhz, reset      clock, synchronous active-high reset
//   eval_pulse, calc_*    job request and its operands / operator code
//   cpu_we/addr/wd        CPU data bus store strobe, byte address, store data
//   mbox_hit, mbox_rd     window decode and read data (combinational)
//   busy, result_valid, result, err_timeout, err_badop   job status

module calc_job_sequencer #(
  parameter logic [31:0] MBOX_BASE      = 32'h0000_0100,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic        clk_50mhz,
  input  logic        reset,
  input  logic        eval_pulse,
  input  logic [31:0] calc_a,
  input  logic [31:0] calc_b,
  input  logic [2:0]  calc_op,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wd,
  output logic        mbox_hit,
  output logic [31:0] mbox_rd,
  output logic        busy,
  output logic        result_valid,
  output logic [31:0] result,
  output logic        err_timeout,
  output logic        err_badop
);

  localparam int unsigned    CW   = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0]  TERM = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE,
    S_TIMEOUT
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [31:0]   reg_a;
  logic [31:0]   reg_b;
  logic [2:0]    reg_op;
  logic [7:0]    seq;
  logic [31:0]   scratch;
  logic          go;

  logic [2:0]    idx;
  logic          wr_scratch;
  logic          wr_done;
  logic          done_match;
  logic [31:0]   status;
  logic          unused_addr_bits;

  // Base is 32-byte aligned, so the offset's low bits are just cpu_addr[4:0].
  assign idx              = cpu_addr[4:2];
  assign mbox_hit         = (cpu_addr[31:5] == MBOX_BASE[31:5]) && (idx < 3'd6);
  assign wr_scratch       = cpu_we && mbox_hit && (idx == 3'd4);
  assign wr_done          = cpu_we && mbox_hit && (idx == 3'd5);
  assign done_match       = wr_done && (cpu_wd[7:0] == seq);
  assign status           = {16'h0000, seq, 4'b0000, err_badop, err_timeout, result_valid, go};
  assign unused_addr_bits = &{1'b0, cpu_addr[1:0]};

  always_comb begin
    mbox_rd = '0;
    if (mbox_hit) begin
      case (idx)
        3'd0:    mbox_rd = reg_a;
        3'd1:    mbox_rd = reg_b;
        3'd2:    mbox_rd = {29'd0, reg_op};
        3'd3:    mbox_rd = status;
        3'd4:    mbox_rd = scratch;
        default: mbox_rd = '0;
      endcase
    end
  end

  always_ff @(posedge clk_50mhz) begin
    if (reset) begin
      state        <= S_IDLE;
      cnt          <= '0;
      reg_a        <= '0;
      reg_b        <= '0;
      reg_op       <= '0;
      seq          <= '0;
      scratch      <= '0;
      go           <= 1'b0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      result       <= '0;
      err_timeout  <= 1'b0;
      err_badop    <= 1'b0;
    end else begin
      if (wr_scratch) begin
        scratch <= cpu_wd;
      end

      case (state)
        S_WAIT: begin
          cnt <= cnt + 1'b1;
          // A matching DONE takes priority over the terminal count.
          if (done_match) begin
            result       <= scratch;
            result_valid <= 1'b1;
            go           <= 1'b0;
            busy         <= 1'b0;
            state        <= S_DONE;
          end else if (cnt == TERM) begin
            err_timeout <= 1'b1;
            go          <= 1'b0;
            busy        <= 1'b0;
            state       <= S_TIMEOUT;
          end
        end

        default: begin
          if (eval_pulse) begin
            result_valid <= 1'b0;
            err_timeout  <= 1'b0;
            if (calc_op <= 3'd4) begin
              reg_a     <= calc_a;
              reg_b     <= calc_b;
              reg_op    <= calc_op;
              seq       <= seq + 8'd1;
              err_badop <= 1'b0;
              cnt       <= '0;
              go        <= 1'b1;
              busy      <= 1'b1;
              state     <= S_WAIT;
            end else begin
              err_badop <= 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_calc_job_sequencer.sv
module tb_calc_job_sequencer;

  logic        clk;
  logic        reset;
  logic        eval_pulse;
  logic [31:0] calc_a;
  logic [31:0] calc_b;
  logic [2:0]  calc_op;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wd;
  logic        mbox_hit;
  logic [31:0] mbox_rd;
  logic        busy;
  logic        result_valid;
  logic [31:0] result;
  logic        err_timeout;
  logic        err_badop;

  int unsigned n_total;
  int unsigned n_pass;

  calc_job_sequencer #(
    .MBOX_BASE      (32'h0000_0100),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk_50mhz    (clk),
    .reset        (reset),
    .eval_pulse   (eval_pulse),
    .calc_a       (calc_a),
    .calc_b       (calc_b),
    .calc_op      (calc_op),
    .cpu_we       (cpu_we),
    .cpu_addr     (cpu_addr),
    .cpu_wd       (cpu_wd),
    .mbox_hit     (mbox_hit),
    .mbox_rd      (mbox_rd),
    .busy         (busy),
    .result_valid (result_valid),
    .result       (result),
    .err_timeout  (err_timeout),
    .err_badop    (err_badop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        eval;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wd;
    logic        exp_hit;
    logic [31:0] exp_rd;
    logic        exp_busy;
    logic        exp_rv;
    logic [31:0] exp_result;
    logic        exp_to;
    logic        exp_bad;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    eval_pulse = 1'b0;
    cpu_we     = 1'b0;
    cpu_wd     = '0;
  endtask

  task automatic read_chk(input string nm, input logic [31:0] addr, input logic [31:0] exp);
    cpu_addr = addr;
    #1;
    chk(nm, mbox_rd, exp);
  endtask

  task automatic chk_flags(input string nm, input logic b, input logic rv,
                           input logic [31:0] res, input logic to, input logic bad);
    chk({nm, ".busy"}, {31'd0, busy}, {31'd0, b});
    chk({nm, ".result_valid"}, {31'd0, result_valid}, {31'd0, rv});
    chk({nm, ".result"}, result, res);
    chk({nm, ".err_timeout"}, {31'd0, err_timeout}, {31'd0, to});
    chk({nm, ".err_badop"}, {31'd0, err_badop}, {31'd0, bad});
  endtask

  task automatic do_eval(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    eval_pulse = 1'b1;
    calc_a     = a;
    calc_b     = b;
    calc_op    = op;
    step();
    idle_inputs();
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] wd);
    cpu_we   = 1'b1;
    cpu_addr = addr;
    cpu_wd   = wd;
    step();
    idle_inputs();
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    reset   = 1'b1;
    calc_a  = '0;
    calc_b  = '0;
    calc_op = '0;
    cpu_addr = '0;
    idle_inputs();

    //            ev a      b      op we addr   wd      hit rd     bsy rv res    to bad
    vecs.push_back('{1, 32'h7, 32'h3, 1, 0, 32'h100, 32'h0, 1, 32'h0,    1, 0, 32'h0,    0, 0});
    vecs.push_back('{0, 32'h0, 32'h0, 0, 0, 32'h10C, 32'h0, 1, 32'h0101, 1, 0, 32'h0,    0, 0});
    vecs.push_back('{0, 32'h0, 32'h0, 0, 0, 32'h100, 32'h0, 1, 32'h7,    1, 0, 32'h0,    0, 0});
    vecs.push_back('{0, 32'h0, 32'h0, 0, 0, 32'h104, 32'h0, 1, 32'h3,    1, 0, 32'h0,    0, 0});
    vecs.push_back('{0, 32'h0, 32'h0, 0, 0, 32'h108, 32'h0, 1, 32'h1,    1, 0, 32'h0,    0, 0});
    vecs.push_back('{0, 32'h0, 32'h0, 0, 1, 32'h110, 32'h4, 1, 32'h0,    1, 0, 32'h0,    0, 0});
    vecs.push_back('{0, 32'h0, 32'h0, 0, 0, 32'h110, 32'h0, 1, 32'h4,    1, 0, 32'h0,    0, 0});
    vecs.push_back('{0, 32'h0, 32'h0, 0, 1, 32'h114, 32'h1, 1, 32'h0,    0, 1, 32'h4,    0, 0});
    vecs.push_back('{0, 32'h0, 32'h0, 0, 0, 32'h10C, 32'h0, 1, 32'h0102, 0, 1, 32'h4,    0, 0});
    vecs.push_back('{0, 32'h0, 32'h0, 0, 0, 32'h200, 32'h0, 0, 32'h0,    0, 1, 32'h4,    0, 0});
    vecs.push_back('{0, 32'h0, 32'h0, 0, 0, 32'h118, 32'h0, 0, 32'h0,    0, 1, 32'h4,    0, 0});
    vecs.push_back('{0, 32'h0, 32'h0, 0, 0, 32'h103, 32'h0, 1, 32'h7,    0, 1, 32'h4,    0, 0});
    vecs.push_back('{1, 32'h9, 32'h9, 5, 0, 32'h108, 32'h0, 1, 32'h1,    0, 0, 32'h4,    0, 1});
    vecs.push_back('{0, 32'h0, 32'h0, 0, 0, 32'h10C, 32'h0, 1, 32'h0108, 0, 0, 32'h4,    0, 1});
    vecs.push_back('{0, 32'h0, 32'h0, 0, 1, 32'h100, 32'hDEAD, 1, 32'h7, 0, 0, 32'h4,    0, 1});
    vecs.push_back('{0, 32'h0, 32'h0, 0, 0, 32'h100, 32'h0, 1, 32'h7,    0, 0, 32'h4,    0, 1});
    vecs.push_back('{1, 32'h11, 32'h22, 4, 0, 32'h10C, 32'h0, 1, 32'h0108, 1, 0, 32'h4, 0, 0});
    vecs.push_back('{1, 32'h55, 32'h66, 2, 0, 32'h100, 32'h0, 1, 32'h11, 1, 0, 32'h4,    0, 0});
    vecs.push_back('{0, 32'h0, 32'h0, 0, 0, 32'h100, 32'h0, 1, 32'h11,   1, 0, 32'h4,    0, 0});
    vecs.push_back('{0, 32'h0, 32'h0, 0, 0, 32'h10C, 32'h0, 1, 32'h0201, 1, 0, 32'h4,    0, 0});
    vecs.push_back('{0, 32'h0, 32'h0, 0, 1, 32'h114, 32'h1, 1, 32'h0,    1, 0, 32'h4,    0, 0});
    vecs.push_back('{0, 32'h0, 32'h0, 0, 1, 32'h110, 32'hABCD, 1, 32'h4, 1, 0, 32'h4,    0, 0});
    vecs.push_back('{0, 32'h0, 32'h0, 0, 1, 32'h114, 32'h2, 1, 32'h0,    0, 1, 32'hABCD, 0, 0});
    vecs.push_back('{0, 32'h0, 32'h0, 0, 0, 32'h10C, 32'h0, 1, 32'h0202, 0, 1, 32'hABCD, 0, 0});
    vecs.push_back('{0, 32'h0, 32'h0, 0, 0, 32'h108, 32'h0, 1, 32'h4,    0, 1, 32'hABCD, 0, 0});

    // Reset state
    step();
    step();
    reset = 1'b0;
    chk_flags("reset", 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    read_chk("reset.status", 32'h10C, 32'h0);

    // Table-driven main flow
    for (int i = 0; i < vecs.size(); i++) begin
      eval_pulse = vecs[i].eval;
      calc_a     = vecs[i].a;
      calc_b     = vecs[i].b;
      calc_op    = vecs[i].op;
      cpu_we     = vecs[i].we;
      cpu_addr   = vecs[i].addr;
      cpu_wd     = vecs[i].wd;
      #1;
      chk($sformatf("vec%0d.hit", i), {31'd0, mbox_hit}, {31'd0, vecs[i].exp_hit});
      chk($sformatf("vec%0d.rd", i), mbox_rd, vecs[i].exp_rd);
      step();
      idle_inputs();
      chk_flags($sformatf("vec%0d", i), vecs[i].exp_busy, vecs[i].exp_rv,
                vecs[i].exp_result, vecs[i].exp_to, vecs[i].exp_bad);
    end

    // Timeout: job seq 3, no DONE; 16 cycles in WAIT
    do_eval(32'h1, 32'h2, 3'd0);
    read_chk("to.status_go", 32'h10C, 32'h0301);
    for (int i = 0; i < 15; i++) step();
    chk("to.still_busy", {31'd0, busy}, 32'd1);
    step();
    chk_flags("to.expired", 1'b0, 1'b0, 32'hABCD, 1'b1, 1'b0);
    read_chk("to.status", 32'h10C, 32'h0304);

    // New job clears err_timeout; seq 4
    do_eval(32'h3, 32'h4, 3'd3);
    chk_flags("to.clear", 1'b1, 1'b0, 32'hABCD, 1'b0, 1'b0);
    read_chk("to.clear_status", 32'h10C, 32'h0401);

    // DONE coinciding with terminal count (cnt==15)
    do_write(32'h110, 32'h77);
    for (int i = 0; i < 14; i++) step();
    chk("tc.busy_before", {31'd0, busy}, 32'd1);
    do_write(32'h114, 32'h4);
    chk_flags("tc.done_wins", 1'b0, 1'b1, 32'h77, 1'b0, 1'b0);

    // Reset mid-WAIT
    do_eval(32'h5, 32'h6, 3'd0);
    step();
    chk("rst.busy_before", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk_flags("rst.mid_wait", 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    read_chk("rst.status", 32'h10C, 32'h0);
    read_chk("rst.scratch", 32'h110, 32'h0);
    read_chk("rst.a", 32'h100, 32'h0);

    // Bad operator in IDLE, then a good job is still accepted from IDLE
    do_eval(32'h8, 32'h1, 3'd7);
    chk_flags("bad.idle", 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    read_chk("bad.status", 32'h10C, 32'h0008);
    read_chk("bad.a_unchanged", 32'h100, 32'h0);
    do_eval(32'h8, 32'h1, 3'd0);
    read_chk("bad.next_accept", 32'h10C, 32'h0101);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
